decompress_stream: RTL and testbench

Streaming Kyber decompressor and unpacker. It is the inverse of the compress path.
- Consumes a packed ciphertext polynomial as 32-bit words, 256 coefficients of d bits each, LSB-first.
- Extracts each d-bit field y and returns x = round(q*y / 2^d) with q = 3329.
- Sits between the ciphertext input buffer and the NTT/polynomial memory on the decapsulation side.

---
 rtl/decompress_stream.sv | 171 +++++++++++++++++
 tb/tb_decompress_stream.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decompress_stream.sv
// decompress_stream: streaming Kyber coefficient unpacker/decompressor.
// Consumes 32-bit packed words (LSB-first d-bit fields, 8*d words per
// polynomial) and emits 256 coefficients x = round(3329*y / 2^d).
// Optional feature macro DECOMP_D12_EN: accepts d = 12 (ByteDecode12),
// where stage 2 reduces y modulo Q instead of multiplying.
module decompress_stream (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_start,
    input  logic [3:0]  i_d,
    input  logic [31:0] i_word,
    input  logic        i_word_valid,
    output logic        o_word_ready,
    output logic [11:0] o_coeff,
    output logic        o_coeff_valid,
    input  logic        i_coeff_ready,
    output logic        o_last,
    output logic        o_busy,
    output logic        o_err
);

    localparam logic [11:0] Q       = 12'd3329;
    localparam logic        ST_IDLE = 1'b0;
    localparam logic        ST_RUN  = 1'b1;

    logic        state_q, state_d;
    logic [3:0]  d_q, d_d;
    logic [43:0] buf_q, buf_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [6:0]  words_q, words_d;
    logic        err_q, err_d;
    logic        s1_valid_q, s1_valid_d;
    logic [11:0] s1_y_q, s1_y_d;
    logic        out_valid_q, out_valid_d;
    logic [11:0] coeff_q, coeff_d;
    logic [7:0]  ocnt_q, ocnt_d;

    logic        run, d_legal, word_ready, word_hs, coeff_hs;
    logic        s1_adv, s2_adv, extract;
    logic [11:0] y_mask, field, x;
    logic [22:0] prod, sum;
    logic [43:0] shifted;
    logic [5:0]  cnt_after;

    // Legal compression widths for a start request
    always_comb begin
        case (i_d)
            4'd1, 4'd4, 4'd5, 4'd10, 4'd11: d_legal = 1'b1;
`ifdef DECOMP_D12_EN
            4'd12:                          d_legal = 1'b1;
`endif
            default:                        d_legal = 1'b0;
        endcase
    end

    assign run        = (state_q == ST_RUN);
    assign word_ready = run && (cnt_q < {2'b00, d_q}) && (words_q < {d_q, 3'b000});
    assign word_hs    = i_word_valid && word_ready;
    assign coeff_hs   = out_valid_q && i_coeff_ready;
    assign s2_adv     = !out_valid_q || i_coeff_ready;
    assign s1_adv     = !s1_valid_q || s2_adv;
    assign extract    = run && (cnt_q >= {2'b00, d_q}) && s1_adv;
    assign y_mask     = 12'((13'd1 << d_q) - 13'd1);
    assign field      = buf_q[11:0] & y_mask;

    // Stage-2 rounding datapath: (Q*y + 2^(d-1)) >> d, or mod-Q for d = 12
    always_comb begin
        prod = 23'(s1_y_q) * 23'(Q);
        sum  = prod + (23'd1 << (d_q - 4'd1));
        x    = 12'(sum >> d_q);
`ifdef DECOMP_D12_EN
        if (d_q == 4'd12) begin
            x = (s1_y_q >= Q) ? (s1_y_q - Q) : s1_y_q;
        end
`endif
    end

    // Next-state: control, bit buffer and the two pipeline stages
    always_comb begin
        state_d     = state_q;
        d_d         = d_q;
        words_d     = words_q;
        ocnt_d      = ocnt_q;
        err_d       = 1'b0;
        s1_valid_d  = s1_valid_q;
        s1_y_d      = s1_y_q;
        out_valid_d = out_valid_q;
        coeff_d     = coeff_q;

        // Extraction shifts first; an accepted word lands above what remains
        shifted   = extract ? (buf_q >> d_q) : buf_q;
        cnt_after = extract ? (cnt_q - {2'b00, d_q}) : cnt_q;
        buf_d     = shifted;
        cnt_d     = cnt_after;
        if (word_hs) begin
            buf_d   = shifted | ({12'b0, i_word} << cnt_after);
            cnt_d   = cnt_after + 6'd32;
            words_d = words_q + 7'd1;
        end

        if (s1_adv) begin
            s1_valid_d = extract;
            if (extract) begin
                s1_y_d = field;
            end
        end
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                coeff_d = x;
            end
        end

        if (coeff_hs) begin
            ocnt_d = ocnt_q + 8'd1;
            if (ocnt_q == 8'd255) begin
                state_d = ST_IDLE;
            end
        end

        if ((state_q == ST_IDLE) && i_start) begin
            if (d_legal) begin
                state_d = ST_RUN;
                d_d     = i_d;
                buf_d   = '0;
                cnt_d   = '0;
                words_d = '0;
                ocnt_d  = '0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= ST_IDLE;
            d_q         <= '0;
            buf_q       <= '0;
            cnt_q       <= '0;
            words_q     <= '0;
            err_q       <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_y_q      <= '0;
            out_valid_q <= 1'b0;
            coeff_q     <= '0;
            ocnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            d_q         <= d_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            words_q     <= words_d;
            err_q       <= err_d;
            s1_valid_q  <= s1_valid_d;
            s1_y_q      <= s1_y_d;
            out_valid_q <= out_valid_d;
            coeff_q     <= coeff_d;
            ocnt_q      <= ocnt_d;
        end
    end

    assign o_word_ready  = word_ready;
    assign o_coeff       = coeff_q;
    assign o_coeff_valid = out_valid_q;
    assign o_last        = out_valid_q && (ocnt_q == 8'd255);
    assign o_busy        = run;
    assign o_err         = err_q;

endmodule

// File: tb/tb_decompress_stream.sv
// Directed bench for decompress_stream: packs coefficient fields into words,
// streams them with optional gaps/backpressure and checks the decoded output.
module tb_decompress_stream;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b1;
    logic        i_start = 1'b0;
    logic [3:0]  i_d = '0;
    logic [31:0] i_word = '0;
    logic        i_word_valid = 1'b0;
    logic        o_word_ready;
    logic [11:0] o_coeff;
    logic        o_coeff_valid;
    logic        i_coeff_ready = 1'b1;
    logic        o_last;
    logic        o_busy;
    logic        o_err;

    int          checks = 0;
    int          errors = 0;
    int          ys[256];
    int          got[256];
    logic [31:0] words[96];

    decompress_stream dut (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .i_start       (i_start),
        .i_d           (i_d),
        .i_word        (i_word),
        .i_word_valid  (i_word_valid),
        .o_word_ready  (o_word_ready),
        .o_coeff       (o_coeff),
        .o_coeff_valid (o_coeff_valid),
        .i_coeff_ready (i_coeff_ready),
        .o_last        (o_last),
        .o_busy        (o_busy),
        .o_err         (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // round(3329*y/2^d) written as floor((2*q*y + 2^d) / 2^(d+1))
    function automatic int ref_x(input int y, input int d);
        if (d == 12) return (y >= 3329) ? y - 3329 : y;
        return (2 * 3329 * y + (1 << d)) / (1 << (d + 1));
    endfunction

    task automatic pack(input int d);
        int pos;
        for (int w = 0; w < 96; w++) words[w] = '0;
        for (int i = 0; i < 256; i++) begin
            for (int b = 0; b < d; b++) begin
                pos = i * d + b;
                words[pos / 32][pos % 32] = 1'((ys[i] >> b) & 1);
            end
        end
    endtask

    task automatic start_poly(input int d);
        @(posedge i_clk); #1;
        i_start = 1'b1;
        i_d     = 4'(d);
        @(posedge i_clk); #1;
        i_start = 1'b0;
    endtask

    task automatic run_poly(input int d, input bit gaps, input bit bp,
                            input int stop_n, input string tag);
        int   widx = 0;
        int   n = 0;
        int   cyc = 0;
        int   nmis = 0;
        int   nlast = 0;
        int   stall_bad = 0;
        bit   prev_stall = 0;
        bit   wh, ch;
        logic [11:0] held = '0;
        i_word_valid  = 1'b1;
        i_word        = words[0];
        i_coeff_ready = 1'b1;
        while (n < stop_n && cyc < 5000) begin
            @(negedge i_clk);
            cyc++;
            if (prev_stall && (!o_coeff_valid || o_coeff !== held)) stall_bad++;
            wh = i_word_valid && o_word_ready;
            ch = o_coeff_valid && i_coeff_ready;
            prev_stall = o_coeff_valid && !i_coeff_ready;
            held = o_coeff;
            if (o_last !== (o_coeff_valid && n == 255)) nlast++;
            if (ch) begin
                got[n] = int'(o_coeff);
                if (int'(o_coeff) != ref_x(ys[n], d)) nmis++;
                n++;
            end
            if (wh) widx++;
            if (n < stop_n) begin
                @(posedge i_clk); #1;
                i_word_valid  = gaps ? ($urandom_range(2) != 0) : 1'b1;
                i_word        = (widx < 96) ? words[widx] : '1;
                i_coeff_ready = bp ? 1'($urandom_range(1)) : 1'b1;
            end
        end
        check({tag, "_count"}, n, stop_n);
        check({tag, "_coeff_mism"}, nmis, 0);
        check({tag, "_last_bad"}, nlast, 0);
        check({tag, "_stall_bad"}, stall_bad, 0);
        if (stop_n == 256) begin
            // keep offering words: no extra word may be taken
            for (int k = 0; k < 4; k++) begin
                @(posedge i_clk); #1;
                i_word_valid  = 1'b1;
                i_word        = '1;
                i_coeff_ready = 1'b1;
                @(negedge i_clk);
                if (i_word_valid && o_word_ready) widx++;
                if (k == 0) begin
                    check({tag, "_busy_fall"}, o_busy, 0);
                    check({tag, "_valid_fall"}, o_coeff_valid, 0);
                end
            end
            check({tag, "_words"}, widx, 8 * d);
            i_word_valid = 1'b0;
        end
    endtask

    initial begin
        #1 i_rstn = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_busy", o_busy, 0);
        check("rst_ready", o_word_ready, 0);
        check("rst_valid", o_coeff_valid, 0);
        check("rst_coeff", o_coeff, 0);
        check("rst_last", o_last, 0);
        check("rst_err", o_err, 0);
        @(negedge i_clk);
        i_rstn = 1'b1;

        // d=1: single set bit in the first field
        for (int i = 0; i < 256; i++) ys[i] = 0;
        ys[0] = 1;
        pack(1);
        start_poly(1);
        check("d1_busy", o_busy, 1);
        run_poly(1, 0, 0, 256, "d1");
        check("d1_c0", got[0], 1665);
        check("d1_c1", got[1], 0);

        // d=4: all ones
        for (int i = 0; i < 256; i++) ys[i] = 15;
        pack(4);
        start_poly(4);
        run_poly(4, 0, 0, 256, "d4");
        check("d4_c0", got[0], 3121);
        check("d4_c255", got[255], 3121);

        // d=5: every field 16
        for (int i = 0; i < 256; i++) ys[i] = 16;
        pack(5);
        start_poly(5);
        run_poly(5, 0, 0, 256, "d5");
        check("d5_c5", got[5], 1665);

        // d=10: fields cross word boundaries
        for (int i = 0; i < 256; i++) ys[i] = (i * 37) % 1024;
        ys[0] = 1023;
        ys[1] = 1;
        pack(10);
        start_poly(10);
        run_poly(10, 0, 0, 256, "d10");
        check("d10_c0", got[0], 3326);
        check("d10_c1", got[1], 3);

        // d=11 with gapped input and random backpressure
        for (int i = 0; i < 256; i++) ys[i] = int'($urandom_range(2047));
        ys[0] = 2047;
        ys[1] = 0;
        pack(11);
        start_poly(11);
        run_poly(11, 1, 1, 256, "d11");
        check("d11_c0", got[0], 3327);
        check("d11_c1", got[1], 0);

        // illegal d, then a normal d=4 run
        @(posedge i_clk); #1;
        i_start = 1'b1;
        i_d     = 4'd3;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        check("err_pulse", o_err, 1);
        check("err_busy", o_busy, 0);
        check("err_ready", o_word_ready, 0);
        @(posedge i_clk); #1;
        check("err_clear", o_err, 0);
        for (int i = 0; i < 256; i++) ys[i] = int'($urandom_range(15));
        pack(4);
        start_poly(4);
        run_poly(4, 0, 0, 256, "d4b");

        // reset after 100 coefficients of d=10
        for (int i = 0; i < 256; i++) ys[i] = int'($urandom_range(1023));
        pack(10);
        start_poly(10);
        run_poly(10, 0, 0, 100, "mid");
        i_rstn = 1'b0;
        #1;
        check("mid_rst_valid", o_coeff_valid, 0);
        check("mid_rst_coeff", o_coeff, 0);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_ready", o_word_ready, 0);
        check("mid_rst_last", o_last, 0);
        i_word_valid  = 1'b0;
        i_coeff_ready = 1'b1;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rstn = 1'b1;
        for (int i = 0; i < 256; i++) ys[i] = int'($urandom_range(1023));
        pack(10);
        start_poly(10);
        run_poly(10, 1, 0, 256, "fresh");

`ifdef DECOMP_D12_EN
        for (int i = 0; i < 256; i++) ys[i] = int'($urandom_range(4095));
        ys[0] = 3330;
        ys[1] = 3328;
        pack(12);
        start_poly(12);
        run_poly(12, 0, 1, 256, "d12");
        check("d12_c0", got[0], 1);
        check("d12_c1", got[1], 3328);
`else
        @(posedge i_clk); #1;
        i_start = 1'b1;
        i_d     = 4'd12;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        check("d12_err", o_err, 1);
        check("d12_busy", o_busy, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
